// File: rtl/delay_pkg.sv
// Shared defaults and FSM state encoding for the sample delay line.
package delay_pkg;

  localparam int DEF_ADDRESS_WIDTH = 9;
  localparam int DEF_DATA_WIDTH    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/delay_ctrl_ram2ports.sv
// Simple dual-port RAM: synchronous write and synchronous registered read on
// independent addresses. Contents are intentionally not reset.
module ram2ports #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/delay_ctrl.sv
// Programmable sample delay line: writes each strobed sample into a circular
// buffer and returns the sample written `offset` strobes earlier.
//
// state | meaning
// IDLE  | no sample accepted since reset
// FILL  | last sample asked for more history than the buffer holds; output masked
// RUN   | last sample's delay was covered by buffered history; output valid data
module delay_ctrl
  import delay_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     out_valid,
  output logic                     filled
);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] fill_cnt;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic [DATA_WIDTH-1:0]    byp_data_q;
  logic                     bypass_q;
  logic                     mask_q;
  logic                     hit;
  logic                     rd_en;

  assign rd_addr = wr_ptr - offset;
  assign hit     = (offset <= fill_cnt);
  // offset 0 would read the address being written this cycle; serve din instead
  assign rd_en   = in_valid && (offset != '0);

  ram2ports #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (in_valid),
    .wr_addr(wr_ptr),
    .wr_data(din),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      out_valid  <= 1'b0;
      mask_q     <= 1'b1;
      bypass_q   <= 1'b0;
      byp_data_q <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        wr_ptr     <= wr_ptr + 1'b1;
        if (fill_cnt != '1) fill_cnt <= fill_cnt + 1'b1;
        state      <= hit ? RUN : FILL;
        mask_q     <= !hit;
        bypass_q   <= (offset == '0);
        byp_data_q <= din;
      end
    end
  end

  // All select terms only change on accepted samples, so dout holds between strobes
  assign dout   = mask_q   ? '0 :
                  bypass_q ? byp_data_q : rd_data;
  assign filled = (state == RUN);

endmodule

// File: tb/tb_delay_ctrl.sv
// Directed bench for delay_ctrl with hand-computed expected outputs.
module tb_delay_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] din;
  logic [8:0] offset;
  logic [7:0] dout;
  logic       out_valid;
  logic       filled;

  int n_cmp = 0;
  int n_err = 0;

  delay_ctrl #(.ADDRESS_WIDTH(9), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .din      (din),
    .offset   (offset),
    .dout     (dout),
    .out_valid(out_valid),
    .filled   (filled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one strobed sample; returns 1 time unit after the capturing edge.
  task automatic send(input logic [7:0] d, input logic [8:0] o);
    in_valid = 1'b1;
    din      = d;
    offset   = o;
    @(posedge clk); #1;
    in_valid = 1'b0;
    din      = 8'hEE;
    offset   = ~o;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  logic [7:0] exp_d;
  logic [7:0] hold_d;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    din      = '0;
    offset   = '0;
    idle(2);

    chk("rst_dout", 16'(dout), 16'h00);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_filled", 16'(filled), 16'h0);
    rst = 1'b0;
    idle(1);

    // offset 2, samples 0x10..0x14 every 4 cycles
    for (int i = 0; i < 5; i++) begin
      exp_d = (i < 2) ? 8'h00 : 8'(8'h10 + i - 2);
      send(8'(8'h10 + i), 9'd2);
      chk($sformatf("s1_ov_%0d", i), 16'(out_valid), 16'h1);
      chk($sformatf("s1_dout_%0d", i), 16'(dout), 16'(exp_d));
      chk($sformatf("s1_filled_%0d", i), 16'(filled), (i >= 2) ? 16'h1 : 16'h0);
      idle(2);
      chk($sformatf("s1_hold_ov_%0d", i), 16'(out_valid), 16'h0);
      chk($sformatf("s1_hold_dout_%0d", i), 16'(dout), 16'(exp_d));
      idle(1);
    end

    // offset 0 bypass from a fresh reset
    do_reset();
    send(8'hA5, 9'd0);
    chk("byp_ov", 16'(out_valid), 16'h1);
    chk("byp_dout", 16'(dout), 16'h00A5);
    chk("byp_filled", 16'(filled), 16'h1);

    // continuous strobes with offset 1
    do_reset();
    in_valid = 1'b1;
    offset   = 9'd1;
    for (int i = 0; i < 8; i++) begin
      din = 8'(8'h30 + i);
      @(posedge clk); #1;
      chk($sformatf("b2b_ov_%0d", i), 16'(out_valid), 16'h1);
      chk($sformatf("b2b_dout_%0d", i), 16'(dout), (i == 0) ? 16'h00 : 16'(8'h30 + i - 1));
    end
    in_valid = 1'b0;
    idle(1);
    chk("b2b_ov_end", 16'(out_valid), 16'h0);

    // RUN with offset 2, then offset 10 drops back to FILL until index 10
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i < 5) begin
        send(8'(8'h40 + i), 9'd2);
        exp_d = (i < 2) ? 8'h00 : 8'(8'h40 + i - 2);
        chk($sformatf("ofs_filled_%0d", i), 16'(filled), (i >= 2) ? 16'h1 : 16'h0);
      end else begin
        send(8'(8'h40 + i), 9'd10);
        exp_d = (i < 10) ? 8'h00 : 8'(8'h40 + i - 10);
        chk($sformatf("ofs_filled_%0d", i), 16'(filled), (i >= 10) ? 16'h1 : 16'h0);
      end
      chk($sformatf("ofs_dout_%0d", i), 16'(dout), 16'(exp_d));
      idle(1);
    end

    // reset with a read in flight
    do_reset();
    in_valid = 1'b1;
    offset   = 9'd1;
    din      = 8'h70;
    @(posedge clk); #1;
    din = 8'h71;
    @(posedge clk); #1;
    chk("rif_pre_dout", 16'(dout), 16'h0070);
    chk("rif_pre_filled", 16'(filled), 16'h1);
    din = 8'h72;
    #2 rst = 1'b1;
    #1;
    chk("rif_dout", 16'(dout), 16'h00);
    chk("rif_out_valid", 16'(out_valid), 16'h0);
    chk("rif_filled", 16'(filled), 16'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rif_suppressed_ov", 16'(out_valid), 16'h0);
    chk("rif_fill_cnt", 16'(dut.fill_cnt), 16'h0);
    rst = 1'b0;
    idle(1);
    send(8'h99, 9'd1);
    chk("rif_after_ov", 16'(out_valid), 16'h1);
    chk("rif_after_dout", 16'(dout), 16'h00);
    chk("rif_after_filled", 16'(filled), 16'h0);

    // 600 back-to-back samples, din = k for k = 1..600, offset 511
    do_reset();
    in_valid = 1'b1;
    offset   = 9'd511;
    for (int k = 1; k <= 600; k++) begin
      din = 8'(k);
      @(posedge clk); #1;
      chk($sformatf("wrap_ov_%0d", k), 16'(out_valid), 16'h1);
      chk($sformatf("wrap_dout_%0d", k), 16'(dout), (k < 512) ? 16'h00 : 16'(8'(k - 511)));
      if (k == 511 || k == 512)
        chk($sformatf("wrap_filled_%0d", k), 16'(filled), (k == 512) ? 16'h1 : 16'h0);
    end
    in_valid = 1'b0;
    chk("wrap_last_dout", 16'(dout), 16'h0059);
    chk("wrap_fill_cnt", 16'(dut.fill_cnt), 16'd511);
    hold_d = dout;
    idle(3);
    chk("wrap_hold_dout", 16'(dout), 16'(hold_d));
    chk("wrap_hold_ov", 16'(out_valid), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/delay_ctrl.md
DELAY_CTRL -- requirements
Module: delay_ctrl

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 9, sets buffer address width; depth is 2**ADDRESS_WIDTH samples.
REQ-002 Parameter DATA_WIDTH, default 8, sets sample width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  one-cycle strobe: din holds a new sample.
REQ-006 din  input  DATA_WIDTH  incoming sample.
REQ-007 offset  input  ADDRESS_WIDTH  requested delay in samples, 0 to 2**ADDRESS_WIDTH-1.
REQ-008 dout  output  DATA_WIDTH  delayed sample.
REQ-009 out_valid  output  1  one-cycle strobe: dout updated.
REQ-010 filled  output  1  high when the buffer holds at least offset prior samples (state RUN).

Function
REQ-011 Write pointer wr_ptr SHALL write din at wr_ptr and then increment on each in_valid, wrapping from 2**ADDRESS_WIDTH-1 to 0.
REQ-012 offset SHALL be sampled only on in_valid cycles and apply to that same sample; changes between strobes SHALL be ignored.
REQ-013 Read address SHALL be (wr_ptr - offset) mod 2**ADDRESS_WIDTH, issued in the in_valid cycle.
REQ-014 out_valid SHALL assert exactly one cycle after each in_valid; dout SHALL hold its value between out_valid pulses.
REQ-015 offset = 0 SHALL bypass the RAM so that dout equals the same sample's din (no read-during-write hazard).
REQ-016 fill_cnt SHALL count accepted samples since reset, saturating at 2**ADDRESS_WIDTH-1.
REQ-017 FSM states: IDLE (no sample since reset), FILL, RUN.
REQ-018 On in_valid the next state SHALL be RUN if offset <= fill_cnt (value before increment), otherwise FILL; with no in_valid, state SHALL hold.
REQ-019 RUN -> FILL SHALL occur when a later sample's offset exceeds fill_cnt.
REQ-020 For any sample accepted outside RUN, dout SHALL be 0 with out_valid still pulsing.
REQ-021 Back-to-back in_valid on every cycle SHALL be supported without loss.
REQ-022 filled SHALL be high iff state is RUN.

Reset
REQ-023 rst SHALL immediately force state IDLE, and wr_ptr, fill_cnt, dout, out_valid and filled to 0.
REQ-024 RAM contents SHALL NOT be cleared; stale data SHALL be masked by REQ-020.
REQ-025 A reset asserted while a read is in flight SHALL suppress that read's out_valid.

Structure
REQ-026 Package delay_pkg SHALL hold default ADDRESS_WIDTH, DATA_WIDTH and the state enum (IDLE, FILL, RUN).
REQ-027 One sub-module SHALL be instantiated: ram2ports (synchronous write, synchronous read, separate wr/rd addresses). The controller SHALL be the sole driver of its ports.

Verification (ADDRESS_WIDTH=9, DATA_WIDTH=8)
REQ-028 After reset, with offset=2, send samples 0x10..0x14 every 4 cycles -> dout sequence 0x00, 0x00, 0x10, 0x11, 0x12, each one cycle after its in_valid; filled rises on the third sample.
REQ-029 offset=0, din=0xA5 -> dout=0xA5 and out_valid=1 on the next cycle.
REQ-030 Send 600 back-to-back samples with din=index[7:0] and offset=511 -> sample 600 outputs 0x59; fill_cnt holds at 511; wrap produces no glitch.
REQ-031 In RUN with offset=2 after 5 samples, change to offset=10 -> filled drops and dout=0 until sample index 10, then dout = din of sample 0.
REQ-032 Assert rst mid-stream with a read in flight -> dout, out_valid and filled are 0 at once; the first sample after reset with offset=1 outputs 0x00.
REQ-033 in_valid on every cycle with offset=1 -> dout stream equals din stream delayed by one sample, with out_valid continuously high.
